bkm_data_step_scoreboard: RTL and testbench

BKM_DATA_STEP_SCOREBOARD -- requirements
Module: bkm_data_step_scoreboard

---
 rtl/bkm_data_step_scoreboard_pkg.sv | 17 +
 rtl/bkm_data_step_scoreboard_if.sv | 39 +++
 rtl/bkm_sat_counter.sv | 18 +
 rtl/bkm_data_step_scoreboard.sv | 106 ++++++++++
 tb/tb_bkm_data_step_scoreboard.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/bkm_data_step_scoreboard_pkg.sv
// Shared definitions for the BKM data-step scoreboard: run-control state
// encoding and a small decode helper. Benches and monitors import this too.
package bkm_data_step_scoreboard_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_REPORT = 2'd3
    } sb_state_t;

    // Samples are accepted in RUN and in the one DRAIN cycle after stop.
    function automatic logic is_sampling(input sb_state_t st);
        return (st == ST_RUN) || (st == ST_DRAIN);
    endfunction

endpackage

// File: rtl/bkm_data_step_scoreboard_if.sv
// Checker-flag inputs and statistics/verdict outputs of the scoreboard.
// master = the side driving checker results, slave = the scoreboard.
interface bkm_data_step_scoreboard_if #(
    parameter int W  = 64,
    parameter int CW = 32
) ();
    logic          enable;
    logic          start;
    logic          stop;
    logic          err_X;
    logic          err_Y;
    logic          war_X;
    logic          war_Y;
    logic [W-1:0]  delta_X;
    logic [W-1:0]  delta_Y;
    logic [CW-1:0] n_samp;
    logic [CW-1:0] n_err_X;
    logic [CW-1:0] n_err_Y;
    logic [CW-1:0] n_war_X;
    logic [CW-1:0] n_war_Y;
    logic [W-1:0]  max_ad_X;
    logic [W-1:0]  max_ad_Y;
    logic          busy;
    logic          rpt_vld;
    logic          pass;
    logic          fail;

    modport master (
        output enable, start, stop, err_X, err_Y, war_X, war_Y, delta_X, delta_Y,
        input  n_samp, n_err_X, n_err_Y, n_war_X, n_war_Y, max_ad_X, max_ad_Y,
               busy, rpt_vld, pass, fail
    );

    modport slave (
        input  enable, start, stop, err_X, err_Y, war_X, war_Y, delta_X, delta_Y,
        output n_samp, n_err_X, n_err_Y, n_war_X, n_war_Y, max_ad_X, max_ad_Y,
               busy, rpt_vld, pass, fail
    );
endinterface

// File: rtl/bkm_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module bkm_sat_counter #(
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] cnt
);
    // Clear has priority over increment; hold once saturated.
    always_ff @(posedge clk) begin
        if (srst || clr)
            cnt <= '0;
        else if (inc && (cnt != {CW{1'b1}}))
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/bkm_data_step_scoreboard.sv
// Scoreboard for the BKM data-step checker: counts samples, errors and
// warnings per axis, tracks the largest |delta|, and issues a pass/fail
// verdict at the end of each start..stop run.
module bkm_data_step_scoreboard
    import bkm_data_step_scoreboard_pkg::*;
#(
    parameter int W       = 64,
    parameter int CW      = 32,
    parameter int ERR_MAX = 0
) (
    input  logic clk,
    input  logic srst,
    bkm_data_step_scoreboard_if.slave sb
);
    localparam logic [CW:0] ERR_LIM = (CW+1)'(ERR_MAX);

    sb_state_t     state, state_nxt;
    logic          enable_d;
    logic          sample_vld;
    logic [W-1:0]  abs_x, abs_y;
    logic [W-1:0]  max_x, max_y;
    logic [CW:0]   err_sum;
    logic          fail_now;
    logic          pass_q, fail_q;

    // Checker flags lag enable by one cycle; align enable to them.
    always_ff @(posedge clk) begin
        if (srst) enable_d <= 1'b0;
        else      enable_d <= sb.enable;
    end

    assign sample_vld = enable_d && is_sampling(state);

    // State register.
    always_ff @(posedge clk) begin
        if (srst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // Next state: start restarts from anywhere and beats stop.
    always_comb begin
        state_nxt = state;
        if (sb.start) begin
            state_nxt = ST_RUN;
        end else begin
            case (state)
                ST_IDLE:   state_nxt = ST_IDLE;
                ST_RUN:    if (sb.stop) state_nxt = ST_DRAIN;
                ST_DRAIN:  state_nxt = ST_REPORT;
                ST_REPORT: state_nxt = ST_IDLE;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    // Statistics; an error masks a warning on the same axis.
    bkm_sat_counter #(.CW(CW)) u_cnt_samp (
        .clk(clk), .srst(srst), .clr(sb.start), .inc(sample_vld), .cnt(sb.n_samp));
    bkm_sat_counter #(.CW(CW)) u_cnt_err_x (
        .clk(clk), .srst(srst), .clr(sb.start), .inc(sample_vld && sb.err_X), .cnt(sb.n_err_X));
    bkm_sat_counter #(.CW(CW)) u_cnt_err_y (
        .clk(clk), .srst(srst), .clr(sb.start), .inc(sample_vld && sb.err_Y), .cnt(sb.n_err_Y));
    bkm_sat_counter #(.CW(CW)) u_cnt_war_x (
        .clk(clk), .srst(srst), .clr(sb.start),
        .inc(sample_vld && !sb.err_X && sb.war_X), .cnt(sb.n_war_X));
    bkm_sat_counter #(.CW(CW)) u_cnt_war_y (
        .clk(clk), .srst(srst), .clr(sb.start),
        .inc(sample_vld && !sb.err_Y && sb.war_Y), .cnt(sb.n_war_Y));

    // W-bit magnitude; the most-negative value maps to 2^(W-1) unsigned.
    assign abs_x = sb.delta_X[W-1] ? (~sb.delta_X + 1'b1) : sb.delta_X;
    assign abs_y = sb.delta_Y[W-1] ? (~sb.delta_Y + 1'b1) : sb.delta_Y;

    // Running maximum of |delta| per axis.
    always_ff @(posedge clk) begin
        if (srst || sb.start) begin
            max_x <= '0;
            max_y <= '0;
        end else if (sample_vld) begin
            if (abs_x > max_x) max_x <= abs_x;
            if (abs_y > max_y) max_y <= abs_y;
        end
    end

    // Error total is one bit wider so two saturated counters cannot wrap.
    assign err_sum  = {1'b0, sb.n_err_X} + {1'b0, sb.n_err_Y};
    assign fail_now = err_sum > ERR_LIM;

    // Latch the verdict as REPORT ends so it holds until the next start.
    always_ff @(posedge clk) begin
        if (srst || sb.start) begin
            pass_q <= 1'b0;
            fail_q <= 1'b0;
        end else if (state == ST_REPORT) begin
            pass_q <= !fail_now;
            fail_q <= fail_now;
        end
    end

    assign sb.max_ad_X = max_x;
    assign sb.max_ad_Y = max_y;
    assign sb.busy     = (state != ST_IDLE);
    assign sb.rpt_vld  = (state == ST_REPORT);
    assign sb.pass     = (state == ST_REPORT) ? !fail_now : pass_q;
    assign sb.fail     = (state == ST_REPORT) ?  fail_now : fail_q;
endmodule

// File: tb/tb_bkm_data_step_scoreboard.sv
// Randomized and directed bench for bkm_data_step_scoreboard (W=8, CW=4).
// Reference rule: every enable driven between the start cycle and the stop
// cycle (inclusive) is one sample, scored with the flags of the next cycle.
module tb_bkm_data_step_scoreboard;
    localparam int W       = 8;
    localparam int CW      = 4;
    localparam int ERR_MAX = 0;
    localparam int CMAX    = (1 << CW) - 1;

    logic clk = 1'b0;
    logic srst;
    int   checks = 0;
    int   errors = 0;

    // Reference-model statistics.
    int m_samp, m_err_x, m_err_y, m_war_x, m_war_y, m_max_x, m_max_y;

    bkm_data_step_scoreboard_if #(.W(W), .CW(CW)) sb ();

    bkm_data_step_scoreboard #(.W(W), .CW(CW), .ERR_MAX(ERR_MAX)) dut (
        .clk(clk), .srst(srst), .sb(sb));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        sb.enable = 0; sb.start = 0; sb.stop = 0;
        sb.err_X = 0; sb.err_Y = 0; sb.war_X = 0; sb.war_Y = 0;
        sb.delta_X = '0; sb.delta_Y = '0;
    endtask

    function automatic int sat(input int v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    function automatic int mag(input logic [W-1:0] d);
        int v;
        v = int'($signed(d));
        return (v < 0) ? -v : v;
    endfunction

    task automatic m_clear();
        m_samp = 0; m_err_x = 0; m_err_y = 0; m_war_x = 0; m_war_y = 0;
        m_max_x = 0; m_max_y = 0;
    endtask

    task automatic m_sample();
        m_samp = sat(m_samp + 1);
        if (sb.err_X) m_err_x = sat(m_err_x + 1);
        else if (sb.war_X) m_war_x = sat(m_war_x + 1);
        if (sb.err_Y) m_err_y = sat(m_err_y + 1);
        else if (sb.war_Y) m_war_y = sat(m_war_y + 1);
        if (mag(sb.delta_X) > m_max_x) m_max_x = mag(sb.delta_X);
        if (mag(sb.delta_Y) > m_max_y) m_max_y = mag(sb.delta_Y);
    endtask

    // Per-cycle stimulus: enable from cycle index i, flags from sample index s.
    task automatic gen(input int mode, input int i, input int s);
        sb.err_X = 0; sb.err_Y = 0; sb.war_X = 0; sb.war_Y = 0;
        sb.delta_X = '0; sb.delta_Y = '0;
        case (mode)
            0: sb.enable = (i < 4);
            1: begin
                sb.enable  = (i < 3);
                sb.delta_X = (s == 0) ? 8'h01 : (s == 1) ? 8'hFE : 8'h80;
                sb.err_X   = (s >= 1);
            end
            2: sb.enable = (i >= 3);
            3: begin
                sb.enable = (i < 20);
                sb.war_Y  = 1'b1;
            end
            default: begin
                sb.enable  = 1'($urandom_range(0, 1));
                sb.err_X   = ($urandom_range(0, 5) == 0);
                sb.err_Y   = ($urandom_range(0, 5) == 0);
                sb.war_X   = ($urandom_range(0, 2) == 0);
                sb.war_Y   = ($urandom_range(0, 2) == 0);
                sb.delta_X = W'($urandom);
                sb.delta_Y = W'($urandom);
            end
        endcase
    endtask

    task automatic check_stats(input string tag);
        chk({tag, ".n_samp"},   64'(sb.n_samp),   64'(m_samp));
        chk({tag, ".n_err_X"},  64'(sb.n_err_X),  64'(m_err_x));
        chk({tag, ".n_err_Y"},  64'(sb.n_err_Y),  64'(m_err_y));
        chk({tag, ".n_war_X"},  64'(sb.n_war_X),  64'(m_war_x));
        chk({tag, ".n_war_Y"},  64'(sb.n_war_Y),  64'(m_war_y));
        chk({tag, ".max_ad_X"}, 64'(sb.max_ad_X), 64'(m_max_x));
        chk({tag, ".max_ad_Y"}, 64'(sb.max_ad_Y), 64'(m_max_y));
    endtask

    // One full run: start at cycle 0, stop at cycle len, one DRAIN cycle,
    // then checks in REPORT and again in the following IDLE cycle.
    task automatic do_run(input int mode, input int len);
        bit pend;
        int s;
        bit exp_fail;
        pend = 0; s = 0;
        m_clear();
        for (int i = 0; i <= len + 1; i++) begin
            sb.start = (i == 0);
            sb.stop  = (i == len);
            gen(mode, i, s);
            if (pend) begin
                m_sample();
                s++;
            end
            pend = sb.enable && (i <= len);
            tick();
        end
        idle_inputs();
        exp_fail = (m_err_x + m_err_y) > ERR_MAX;
        chk("rpt.rpt_vld", 64'(sb.rpt_vld), 64'd1);
        chk("rpt.busy",    64'(sb.busy),    64'd1);
        chk("rpt.pass",    64'(sb.pass),    64'(!exp_fail));
        chk("rpt.fail",    64'(sb.fail),    64'(exp_fail));
        check_stats("rpt");
        tick();
        chk("post.rpt_vld", 64'(sb.rpt_vld), 64'd0);
        chk("post.busy",    64'(sb.busy),    64'd0);
        chk("post.pass",    64'(sb.pass),    64'(!exp_fail));
        chk("post.fail",    64'(sb.fail),    64'(exp_fail));
        check_stats("post");
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".busy"},    64'(sb.busy),    64'd0);
        chk({tag, ".rpt_vld"}, 64'(sb.rpt_vld), 64'd0);
        chk({tag, ".pass"},    64'(sb.pass),    64'd0);
        chk({tag, ".fail"},    64'(sb.fail),    64'd0);
        m_clear();
        check_stats(tag);
    endtask

    initial begin
        idle_inputs();
        srst = 1'b1;
        tick();
        tick();
        check_all_zero("reset");
        srst = 1'b0;
        tick();

        // Clean run: 4 samples, no flags.
        do_run(0, 4);
        chk("clean.n_samp", 64'(sb.n_samp), 64'd4);
        chk("clean.pass",   64'(sb.pass),   64'd1);

        // Error sequence with the most-negative delta.
        do_run(1, 3);
        chk("errseq.max_ad_X", 64'(sb.max_ad_X), 64'h80);
        chk("errseq.n_err_X",  64'(sb.n_err_X),  64'd2);
        chk("errseq.fail",     64'(sb.fail),     64'd1);

        // Enable in the stop cycle lands in DRAIN; enable in DRAIN is dropped.
        do_run(2, 3);
        chk("drain.n_samp", 64'(sb.n_samp), 64'd1);

        // Warning saturation on Y.
        do_run(3, 20);
        chk("sat.n_war_Y", 64'(sb.n_war_Y), 64'd15);
        chk("sat.pass",    64'(sb.pass),    64'd1);

        // Randomized runs.
        for (int r = 0; r < 25; r++)
            do_run(9, $urandom_range(2, 30));

        // srst mid-run after 3 samples discards everything.
        sb.start = 1; sb.enable = 1;
        tick();
        sb.start = 0;
        tick();
        tick();
        sb.enable = 0;
        tick();
        chk("midrun.n_samp", 64'(sb.n_samp), 64'd3);
        srst = 1'b1;
        tick();
        srst = 1'b0;
        check_all_zero("srst");
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("srst.no_rpt", 64'(sb.rpt_vld), 64'd0);
        end

        // start and stop together: start wins, counters cleared.
        sb.start = 1; sb.enable = 1;
        tick();
        sb.start = 0;
        tick();
        tick();
        sb.enable = 0;
        tick();
        chk("ss.pre_n_samp", 64'(sb.n_samp), 64'd3);
        sb.start = 1; sb.stop = 1;
        tick();
        sb.start = 0; sb.stop = 0;
        chk("ss.busy",   64'(sb.busy),   64'd1);
        chk("ss.n_samp", 64'(sb.n_samp), 64'd0);
        tick();
        chk("ss.still_run", 64'(sb.busy), 64'd1);
        sb.stop = 1;
        tick();
        sb.stop = 0;
        tick();
        chk("ss.rpt_vld", 64'(sb.rpt_vld), 64'd1);
        chk("ss.pass",    64'(sb.pass),    64'd1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
